capture_event_logger: RTL
=========================

CAPTURE_EVENT_LOGGER -- requirements
Module: capture_event_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DATA_W, default 32, width of counter and captured values.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic rising-edge triggered.
REQ-004 SHALL have port rst_an_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous flush of FIFO and status.
REQ-006 SHALL have port capture_strobe_i  input  1  one-cycle pulse, capture event.
REQ-007 SHALL have port captured_i  input  DATA_W  captured timer value, valid with capture_strobe_i.
REQ-008 SHALL have port alarm_i  input  1  timer alarm level.
REQ-009 SHALL have port counter_i  input  DATA_W  live timer counter value.
REQ-010 SHALL have port evt_valid_o  output  1  head entry available.
REQ-011 SHALL have port evt_ready_i  input  1  consumer accepts head entry.
REQ-012 SHALL have port evt_data_o  output  DATA_W  head entry value.
REQ-013 SHALL have port evt_type_o  output  1  head entry type: 0 = capture, 1 = alarm.
REQ-014 SHALL have port level_o  output  log2(DEPTH)+1  current entry count.
REQ-015 SHALL have port overflow_o  output  1  sticky: at least one event dropped.
REQ-016 SHALL have port drop_cnt_o  output  8  dropped-event count, saturating at 255.

Function
REQ-017 SHALL detect an alarm event as a 0->1 transition of alarm_i against a registered copy; the entry value is counter_i in the detect cycle.
REQ-018 SHALL push a capture event as {type 0, captured_i} in the cycle capture_strobe_i is high.
REQ-019 SHALL give capture priority when both events occur in one cycle; the alarm entry is held in a one-deep pending register and pushed the next cycle.
REQ-020 SHALL, if a pending alarm meets a new capture, push the capture, keep the pending alarm, and drop any further new alarm edge as overflow.
REQ-021 SHALL present entries first-word-fall-through: with the FIFO empty, an event in cycle N gives evt_valid_o=1 with its data in cycle N+1.
REQ-022 SHALL pop the head when evt_valid_o and evt_ready_i are both 1; evt_data_o/evt_type_o SHALL stay stable while evt_valid_o=1 and evt_ready_i=0.
REQ-023 SHALL accept a push and a pop in the same cycle when full; the push succeeds and level_o is unchanged.
REQ-024 SHALL drop a push when full with no pop that cycle, set overflow_o, and increment drop_cnt_o, saturating at 255.
REQ-025 SHALL keep entries in event order, with pointers wrapping modulo DEPTH.
REQ-026 SHALL, on clear_i=1, next cycle: empty the FIFO, level_o=0, overflow_o=0, drop_cnt_o=0, pending alarm cleared; events in the clear cycle are discarded and not counted.
REQ-027 SHALL keep the alarm edge register updating during clear_i, so no false edge follows a clear.

Reset
REQ-028 SHALL, with rst_an_i=0 at a clock edge, set evt_valid_o=0, evt_data_o=0, evt_type_o=0, level_o=0, overflow_o=0, drop_cnt_o=0, and clear the pending alarm and the alarm edge register.
REQ-029 SHALL give reset priority over clear_i and all events; an alarm_i already high at reset release SHALL NOT create an event.

Structure
REQ-030 SHALL put DEPTH/DATA_W defaults, EVT_CAPTURE=0 / EVT_ALARM=1 encodings, and drop-counter width in the shared timer package.
REQ-031 SHALL implement storage in one sub-module, sync_fifo (width DATA_W+1, depth DEPTH, FWFT, full/empty/level); event arbitration and status stay in the top of this block.

Verification
REQ-032 SHALL cover: capture strobe with captured_i=0x0000_1234 on an empty FIFO -> next cycle evt_valid_o=1, data 0x1234, type 0, level_o=1.
REQ-033 SHALL cover: alarm_i rises while counter_i=0x64 and a capture of 0x50 occurs in the same cycle -> entries read back in order (0x50, type 0), then (0x64, type 1).
REQ-034 SHALL cover: 10 captures with evt_ready_i=0 and DEPTH=8 -> level_o=8, overflow_o=1, drop_cnt_o=2; the first 8 values drain in order.
REQ-035 SHALL cover: full FIFO, capture and evt_ready_i=1 in the same cycle -> level_o stays 8, overflow_o stays 0, and the new value is last out.
REQ-036 SHALL cover: clear_i pulsed together with a capture while 3 entries are held -> next cycle level_o=0, evt_valid_o=0, drop_cnt_o=0.
REQ-037 SHALL cover: reset asserted mid-drain with alarm_i held high through reset release -> all outputs 0 and no alarm entry produced.

Source files
------------

// File: rtl/capture_event_logger_pkg.sv
// Shared definitions for the capture event logger.
// Holds the default FIFO depth and data width, the event-type encodings
// stored alongside each entry, and the width of the dropped-event counter.
package capture_event_logger_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int DATA_W_DEF = 32;
  localparam int DROP_CNT_W = 8;

  // Event type bit stored as the MSB of each FIFO entry
  localparam logic EVT_CAPTURE = 1'b0;
  localparam logic EVT_ALARM   = 1'b1;

endpackage

// File: rtl/capture_event_logger_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_an_i    clock, synchronous active-low reset
//   clr_i              synchronous flush (pointers and count to zero)
//   push_i, data_i     write request and data; accepted when not full, or
//                      when full and a pop happens in the same cycle
//   pop_i              read request; ignored when empty
//   data_o             head entry, forced to zero while empty
//   full_o, empty_o    status flags
//   level_o            current entry count
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_an_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = pop_i & ~w_empty;
  // A pop frees the slot the write lands in, so full + pop still accepts
  assign w_do_push = push_i & (~w_full | w_do_pop);

  // Power-of-two depth: pointers wrap by natural overflow
  always_ff @(posedge clk_i) begin
    if (!rst_an_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the read path is masked while empty instead
  always_ff @(posedge clk_i) begin
    if (rst_an_i && !clr_i && w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign level_o = r_count;

endmodule

// File: rtl/capture_event_logger.sv
// capture_event_logger: merges timer capture strobes and alarm rising edges
// into an ordered event FIFO with overflow accounting.
// Ports:
//   clk_i, rst_an_i          clock, synchronous active-low reset
//   clear_i                  synchronous flush of FIFO, pending alarm, status
//   capture_strobe_i         capture event, value on captured_i
//   alarm_i                  alarm level; a rising edge logs counter_i
//   evt_valid_o/evt_ready_i  FWFT handshake for the head entry
//   evt_data_o, evt_type_o   head value and type (0 capture, 1 alarm)
//   level_o                  entries held
//   overflow_o, drop_cnt_o   sticky drop flag and saturating drop count
module capture_event_logger
  import capture_event_logger_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_an_i,
  input  logic                    clear_i,
  input  logic                    capture_strobe_i,
  input  logic [DATA_W-1:0]       captured_i,
  input  logic                    alarm_i,
  input  logic [DATA_W-1:0]       counter_i,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [DATA_W-1:0]       evt_data_o,
  output logic                    evt_type_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o,
  output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

  logic                  r_alarm_q;
  logic                  r_arm;
  logic                  r_pend_vld;
  logic [DATA_W-1:0]     r_pend_data;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_alarm_edge;
  logic                  w_push;
  logic [DATA_W:0]       w_push_data;
  logic                  w_pend_load;
  logic                  w_edge_drop;
  logic                  w_full_drop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [DATA_W:0]       w_fifo_data;
  logic [DROP_CNT_W:0]   w_drop_sum;
  logic [DROP_CNT_W-1:0] w_drop_next;

  // r_arm stays low for the first cycle after reset so an alarm already high
  // at release is absorbed into r_alarm_q instead of reading as an edge.
  assign w_alarm_edge = r_arm & alarm_i & ~r_alarm_q;

  // Capture wins the single push slot; an alarm that loses goes to the
  // one-deep pending register, and a further edge while it is occupied
  // by a blocked alarm is dropped.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    w_pend_load = 1'b0;
    w_edge_drop = 1'b0;
    if (capture_strobe_i) begin
      w_push      = 1'b1;
      w_push_data = {EVT_CAPTURE, captured_i};
      if (r_pend_vld) w_edge_drop = w_alarm_edge;
      else            w_pend_load = w_alarm_edge;
    end else if (r_pend_vld) begin
      w_push      = 1'b1;
      w_push_data = {EVT_ALARM, r_pend_data};
      w_pend_load = w_alarm_edge;
    end else if (w_alarm_edge) begin
      w_push      = 1'b1;
      w_push_data = {EVT_ALARM, counter_i};
    end
  end

  assign w_pop       = ~w_empty & evt_ready_i;
  assign w_full_drop = w_push & w_full & ~w_pop;

  // At most two drops per cycle; one spare bit detects saturation
  assign w_drop_sum  = {1'b0, r_drop_cnt}
                     + (DROP_CNT_W+1)'(w_full_drop)
                     + (DROP_CNT_W+1)'(w_edge_drop);
  assign w_drop_next = w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_an_i) begin
      r_alarm_q   <= 1'b0;
      r_arm       <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      // Edge history tracks through clear so no false edge follows it
      r_alarm_q <= alarm_i;
      r_arm     <= 1'b1;
      if (clear_i) begin
        r_pend_vld <= 1'b0;
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else begin
        r_pend_vld <= (capture_strobe_i & r_pend_vld) | w_pend_load;
        if (w_pend_load) r_pend_data <= counter_i;
        if (w_full_drop | w_edge_drop) r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_next;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_an_i (rst_an_i),
    .clr_i    (clear_i),
    .push_i   (w_push),
    .data_i   (w_push_data),
    .pop_i    (w_pop),
    .data_o   (w_fifo_data),
    .full_o   (w_full),
    .empty_o  (w_empty),
    .level_o  (level_o)
  );

  assign evt_valid_o = ~w_empty;
  assign evt_type_o  = w_fifo_data[DATA_W];
  assign evt_data_o  = w_fifo_data[DATA_W-1:0];
  assign overflow_o  = r_overflow;
  assign drop_cnt_o  = r_drop_cnt;

endmodule
